// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the fetch-entry record for the fetch unit
package fetch_pkg;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] FETCH_IM_LIMIT = 32'h0000_6FFC;
  localparam logic [31:0] FETCH_NOP = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic exc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: two-entry in-order FIFO of fetch entries with flush
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t e0, e1;
  logic [1:0] base;
  // occupancy after the pop, which is also the slot the push lands in
  assign base = count - {1'b0, pop};
  assign head = e0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      e0 <= '0;
      e1 <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop) e0 <= e1;
      if (push && base == 2'd0) e0 <= entry;
      if (push && base != 2'd0) e1 <= entry;
      count <= base + {1'b0, push};
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing with redirect, illegal-address flagging and a 2-deep fetch buffer
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [31:0] IM_LIMIT = FETCH_IM_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_exc
);
  logic [31:0] pc;
  logic [1:0] count;
  logic dequeue, fetch_en, exc;
  fetch_entry_t entry, head;
  assign out_valid = count != 2'd0;
  assign dequeue = out_valid && out_ready;
  assign fetch_en = !redirect_valid && (count < 2'd2 || dequeue);
  assign exc = pc[1:0] != 2'b00 || pc < RESET_PC || pc > IM_LIMIT;
  assign entry = '{pc: pc, instr: exc ? FETCH_NOP : imem_instr, exc: exc};
  assign imem_addr = pc;
  assign out_instr = head.instr;
  assign out_pc = head.pc;
  assign out_exc = head.exc;
  always_ff @(posedge clk or negedge reset)
    if (!reset) pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (fetch_en) pc <= pc + 32'd4;
  // a handshake coinciding with a redirect is consumed; the flush empties the buffer anyway
  fetch_buffer u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (fetch_en),
    .pop   (dequeue),
    .flush (redirect_valid),
    .entry (entry),
    .head  (head),
    .count (count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random traffic against a queue-based fetch model
module tb_fetch_unit;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic exc;
  } ment_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] imem_addr, imem_instr, redirect_pc, out_instr, out_pc;
  logic redirect_valid, out_valid, out_ready, out_exc;
  int tests = 0;
  int fails = 0;
  ment_t mq[$];
  logic [31:0] mpc;
  logic [31:0] targets[9] = '{32'h3000, 32'h3100, 32'h3102, 32'h2FFC, 32'h6FF8,
                              32'h6FFC, 32'h7000, 32'h4001, 32'hFFFF_FFF8};
  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_exc(out_exc)
  );
  always #5 clk = ~clk;
  assign imem_instr = imem_addr ^ 32'hFFFF;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit illegal(input logic [31:0] a);
    return a % 4 != 0 || a < 32'h3000 || a > 32'h6FFC;
  endfunction
  task automatic model_reset();
    mq.delete();
    mpc = 32'h3000;
  endtask
  task automatic compare();
    check("valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    check("imem_addr", imem_addr, mpc);
    if (mq.size() != 0) begin
      check("head_pc", out_pc, mq[0].pc);
      check("head_instr", out_instr, mq[0].instr);
      check("head_exc", {31'd0, out_exc}, {31'd0, mq[0].exc});
    end
  endtask
  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
    bit deq, fe;
    redirect_valid = rv;
    redirect_pc = rpc;
    out_ready = rdy;
    deq = mq.size() != 0 && rdy;
    fe = !rv && (mq.size() < 2 || deq);
    if (rv) begin
      mq.delete();
      mpc = rpc;
    end else begin
      if (deq) mq.delete(0);
      if (fe) begin
        mq.push_back('{pc: mpc, instr: illegal(mpc) ? 32'h0 : mpc ^ 32'hFFFF, exc: illegal(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    @(negedge clk);
    compare();
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h3000);
    check({tag, "_pc"}, out_pc, 32'h0);
    check({tag, "_instr"}, out_instr, 32'h0);
    check({tag, "_exc"}, {31'd0, out_exc}, 32'd0);
  endtask
  task automatic restart();
    @(negedge clk);
    reset = 1'b0;
    #1 check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask
  initial begin
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    model_reset();
    #12 check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b1);
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_pc", out_pc, 32'h3000 + 32'(4 * i));
      check("stream_instr", out_instr, (32'h3000 + 32'(4 * i)) ^ 32'hFFFF);
    end
    restart();
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0);
    check("stall_pc", out_pc, 32'h3000);
    check("stall_addr", imem_addr, 32'h3008);
    cyc(1'b1, 32'h3100, 1'b0);
    check("redir_bubble", {31'd0, out_valid}, 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    check("redir_pc", out_pc, 32'h3100);
    cyc(1'b1, 32'h3102, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    check("mis_exc", {31'd0, out_exc}, 32'd1);
    check("mis_instr", out_instr, 32'h0);
    cyc(1'b0, 32'h0, 1'b1);
    check("mis_next_pc", out_pc, 32'h3106);
    cyc(1'b1, 32'h6FF8, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1);
    check("lim_pc", out_pc, 32'h7000);
    check("lim_exc", {31'd0, out_exc}, 32'd1);
    check("lim_instr", out_instr, 32'h0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 3) == 0) ? {$urandom_range(32'h3000, 32'h6FFC)} & ~32'h3
                                      : targets[$urandom_range(0, 8)];
      cyc($urandom_range(0, 7) == 0, t, $urandom_range(0, 3) != 0);
    end
    cyc(1'b1, 32'h5000, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    check("mid_full_pc", out_pc, 32'h5000);
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) cyc(1'b0, 32'h0, $urandom_range(0, 1) == 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
